req_priority_encoder: RTL and testbench

- Inverse of the team's 2-to-4 decoder: a registered encoder that turns one-hot/multi-hot request lines back into a binary index.
- Request pulses are latched into a pending register. One binary index is issued at a time over a valid/ready handshake, and its pending bit is cleared on acceptance.
- Sits between peripheral/interrupt-style request lines and the CPU control unit, which consumes the index.

---
 rtl/req_priority_encoder_pkg.sv | 18 +
 rtl/req_priority_encoder_prio_pick.sv | 31 +++
 rtl/req_priority_encoder.sv | 104 ++++++++++
 tb/tb_req_priority_encoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/req_priority_encoder_pkg.sv
// Shared definitions for the request priority encoder.
// Optional round-robin priority is enabled with REQ_PRIORITY_ENCODER_RR_EN.
package req_enc_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = $clog2(N_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One-hot of an index; callers truncate to their own request width (N <= 32).
  function automatic logic [31:0] onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/req_priority_encoder_prio_pick.sv
// Combinational picker: first set bit of vec, searching upward from base with
// wrap-around. base=0 gives plain lowest-index priority.
module prio_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] base,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] pos;
  logic         found;

  // Scan N positions starting at base; W-bit addition wraps modulo N.
  always_comb begin
    idx   = '0;
    any   = |vec;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = base + W'(i);
      if (!found && vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_priority_encoder.sv
// Registered request encoder: latches request pulses into a pending register
// and issues one binary index at a time over a valid/ready handshake.
// Define REQ_PRIORITY_ENCODER_RR_EN for round-robin priority; otherwise the
// lowest pending index always wins.
//
// state | meaning
// IDLE  | output slot empty, enc_valid=0
// HOLD  | output slot holds enc_idx, enc_valid=1
module req_priority_encoder
  import req_enc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = 8,
  localparam int W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic             enc_valid,
  input  logic             enc_ready,
  output logic [W-1:0]     enc_idx,
  output logic [N-1:0]     pending,
  output logic [CNT_W-1:0] lost_cnt
);

  state_t       state, state_nxt;
  logic         load;
  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic [W-1:0] base;
  logic [N-1:0] clr_mask;
  logic         collide;

`ifdef REQ_PRIORITY_ENCODER_RR_EN
  logic [W-1:0] last_issued;

  // Remember the most recently loaded index so the search starts just past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_issued <= W'(N - 1);
    else if (load) last_issued <= pick_idx;
  end

  assign base = last_issued + W'(1);
`else
  assign base = '0;
`endif

  prio_pick #(.N(N)) u_pick (
    .vec  (pending),
    .base (base),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Next state and slot-load decision; a load in HOLD is the back-to-back case.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (enc_ready) begin
          if (pick_any) load = 1'b1;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_mask  = load ? N'(onehot(5'(pick_idx))) : '0;
  assign collide   = |(req & pending & ~clr_mask);
  assign enc_valid = (state == HOLD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pending bits: new requests win over the clear of the index being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | req;
  end

  // Output slot index, held steady until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    enc_idx <= '0;
    else if (load) enc_idx <= pick_idx;
  end

  // Saturating count of cycles where a request hit an already-pending bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          lost_cnt <= '0;
    else if (collide && lost_cnt != '1)  lost_cnt <= lost_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_req_priority_encoder.sv
// Self-checking bench for req_priority_encoder (N=4, CNT_W=8).
module tb_req_priority_encoder;

  localparam int N = 4;
`ifdef REQ_PRIORITY_ENCODER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         enc_ready = 1'b0;
  logic         enc_valid;
  logic [1:0]   enc_idx;
  logic [N-1:0] pending;
  logic [7:0]   lost_cnt;

  int n_pass = 0;
  int n_total = 0;
  int acc_log[$];

  req_priority_encoder #(.N(N), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .enc_valid (enc_valid),
    .enc_ready (enc_ready),
    .enc_idx   (enc_idx),
    .pending   (pending),
    .lost_cnt  (lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a set of pending request numbers and an output slot.
  bit m_pend[N];
  bit m_valid = 1'b0;
  int m_idx = 0;
  int m_lost = 0;
  int m_last = N - 1;

  function automatic int m_pick(input int start);
    for (int k = 0; k < N; k++)
      if (m_pend[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic int m_pend_int();
    int v = 0;
    for (int j = 0; j < N; j++) if (m_pend[j]) v += (1 << j);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) m_pend[j] = 1'b0;
      m_valid = 1'b0; m_idx = 0; m_lost = 0; m_last = N - 1;
    end else begin
      int  p;
      bit  ld;
      bit  hit;
      p   = m_pick(RR ? (m_last + 1) % N : 0);
      ld  = (p >= 0) && (!m_valid || enc_ready);
      hit = 1'b0;
      for (int j = 0; j < N; j++)
        if (req[j] && m_pend[j] && !(ld && j == p)) hit = 1'b1;
      if (hit && m_lost < 255) m_lost++;
      if (ld) m_pend[p] = 1'b0;
      for (int j = 0; j < N; j++) if (req[j]) m_pend[j] = 1'b1;
      if (ld) begin
        m_valid = 1'b1; m_idx = p; m_last = p;
      end else if (m_valid && enc_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, plus acceptance logging.
  always @(negedge clk) begin
    chk("valid", int'(enc_valid), int'(m_valid));
    if (m_valid) chk("idx", int'(enc_idx), m_idx);
    chk("pending", int'(pending), m_pend_int());
    chk("lost_cnt", int'(lost_cnt), m_lost);
    if (enc_valid && enc_ready && rst_n) acc_log.push_back(int'(enc_idx));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; enc_ready = 1'b0; rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    acc_log.delete();
  endtask

  initial begin
    int cnt2;
    logic [N-1:0] v;
    repeat (3) cyc();
    chk("rst_valid", int'(enc_valid), 0);
    chk("rst_idx", int'(enc_idx), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_lost", int'(lost_cnt), 0);
    rst_n = 1'b1;
    cyc();

    // One-hot sweep: valid two edges after the request edge.
    enc_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      v = '0; v[k] = 1'b1;
      req = v; cyc(); req = '0;
      chk("sweep_pend", int'(pending), int'(v));
      chk("sweep_early_valid", int'(enc_valid), 0);
      cyc();
      chk("sweep_valid", int'(enc_valid), 1);
      chk("sweep_idx", int'(enc_idx), k);
      cyc();
      chk("sweep_idle", int'(enc_valid), 0);
    end

    // Multi-hot: 1010 -> 1 then 3 back to back.
    do_reset();
    enc_ready = 1'b1;
    req = 4'b1010; cyc(); req = '0;
    cyc();
    chk("multi_idx1", int'(enc_idx), 1);
    chk("multi_pend1", int'(pending), 4'b1000);
    cyc();
    chk("multi_valid3", int'(enc_valid), 1);
    chk("multi_idx3", int'(enc_idx), 3);
    chk("multi_pend3", int'(pending), 0);
    cyc();
    chk("multi_done", int'(enc_valid), 0);

    // Backpressure.
    do_reset();
    req = 4'b0110; cyc(); req = '0;
    repeat (5) cyc();
    chk("bp_valid", int'(enc_valid), 1);
    chk("bp_idx", int'(enc_idx), 1);
    chk("bp_pend", int'(pending), 4'b0100);
    enc_ready = 1'b1;
    cyc(); cyc();
    enc_ready = 1'b0;
    chk("bp_count", acc_log.size(), 2);
    if (acc_log.size() >= 2) begin
      chk("bp_first", acc_log[0], 1);
      chk("bp_second", acc_log[1], 2);
    end

    // Lost requests and saturation.
    do_reset();
    req = 4'b0001;
    repeat (3) cyc();
    chk("lost_one", int'(lost_cnt), 1);
    repeat (300) cyc();
    chk("lost_sat", int'(lost_cnt), 255);

    // Reset while holding: nothing issued afterwards without new requests.
    do_reset();
    repeat (3) cyc();
    chk("rst_hold_valid", int'(enc_valid), 0);
    chk("rst_hold_pend", int'(pending), 0);
    chk("rst_hold_lost", int'(lost_cnt), 0);

    // Re-request of the index in the slot on its accept cycle.
    do_reset();
    req = 4'b0100; cyc(); req = '0;
    cyc();
    chk("sw_idx", int'(enc_idx), 2);
    chk("sw_pend0", int'(pending), 0);
    enc_ready = 1'b1; req = 4'b0100; cyc(); req = '0;
    chk("sw_gap", int'(enc_valid), 0);
    chk("sw_pend", int'(pending), 4'b0100);
    cyc();
    chk("sw_again", int'(enc_idx), 2);
    cyc();
    enc_ready = 1'b0;
    cnt2 = 0;
    foreach (acc_log[i]) if (acc_log[i] == 2) cnt2++;
    chk("sw_twice", cnt2, 2);

    // Saturated request vector: round-robin rotates, fixed priority repeats 0.
    do_reset();
    enc_ready = 1'b1;
    req = 4'b1111;
    repeat (8) cyc();
    req = '0;
    repeat (10) cyc();
    enc_ready = 1'b0;
    chk("all_count_ge8", int'(acc_log.size() >= 8), 1);
    if (acc_log.size() >= 8)
      for (int i = 0; i < 8; i++)
        chk("all_seq", acc_log[i], RR ? (i % 4) : 0);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
